// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART transmitter and receiver.
// Holds the baud divisor table, the receiver state encoding and the oversampling ratios.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;
    localparam int DIV_W      = 14;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

    // clk cycles per 16x sample tick at 50 MHz
    function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel);
        case (sel)
            3'b000:  return 14'd10417;
            3'b001:  return 14'd2604;
            3'b010:  return 14'd651;
            3'b011:  return 14'd326;
            3'b100:  return 14'd163;
            3'b101:  return 14'd81;
            3'b110:  return 14'd54;
            default: return 14'd27;
        endcase
    endfunction

endpackage

// File: rtl/baud_controller.sv
// baud_controller: 16x oversample tick generator.
// restart zeroes the phase and latches baud_select for the coming frame.
module baud_controller
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       restart,
    output logic       sample_en
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;

    assign sample_en = !restart && cnt == div - 1'b1;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt <= '0;
            div <= baud_div(baud_select);
        end else begin
            cnt <= sample_en ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x oversampled UART receiver with one-cycle valid/error strobes.
// Define UART_RX_PARITY_EN for frames with an even parity bit before the stop bit.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_FERROR,
    output logic       Rx_PERROR
);

    localparam logic [3:0] MID_LAST = 4'(MID_SAMPLE - 1);
    localparam logic [3:0] BIT_LAST = 4'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = PARITY;
    logic par_bad;
`else
    localparam rx_state_t AFTER_DATA = STOP;
    assign Rx_PERROR = 1'b0;
`endif

    rx_state_t              state;
    logic [SYNC_STAGES-1:0] sync;
    logic [3:0]             tcnt;
    logic [2:0]             bcnt;
    logic [7:0]             shreg;
    logic                   need_high;
    logic                   rx;
    logic                   restart;
    logic                   sample_en;
    logic                   bit_end;

    assign rx      = sync[SYNC_STAGES-1];
    // after a framing error the line must return high first, so a held break yields one frame
    assign restart = state == IDLE && Rx_EN && !rx && !need_high;
    assign bit_end = sample_en && tcnt == BIT_LAST;

    baud_controller u_baud (
        .clk(clk),
        .reset(reset),
        .baud_select(baud_select),
        .restart(restart),
        .sample_en(sample_en)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sync      <= '1;
            state     <= IDLE;
            tcnt      <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            need_high <= 1'b0;
            Rx_DATA   <= '0;
            Rx_VALID  <= 1'b0;
            Rx_FERROR <= 1'b0;
`ifdef UART_RX_PARITY_EN
            Rx_PERROR <= 1'b0;
            par_bad   <= 1'b0;
`endif
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], RxD};
            Rx_VALID  <= 1'b0;
            Rx_FERROR <= 1'b0;
`ifdef UART_RX_PARITY_EN
            Rx_PERROR <= 1'b0;
`endif
            if (sample_en) tcnt <= tcnt == BIT_LAST ? '0 : tcnt + 1'b1;
            if (state != IDLE && !Rx_EN) state <= IDLE;
            else case (state)
                IDLE: begin
                    if (rx) need_high <= 1'b0;
                    if (restart) begin
                        state <= START;
                        tcnt  <= '0;
                        bcnt  <= '0;
                    end
                end
                START: if (sample_en && tcnt == MID_LAST) begin
                    tcnt  <= '0;
                    state <= rx ? IDLE : DATA;
                end
                DATA: if (bit_end) begin
                    shreg <= {rx, shreg[7:1]};
                    bcnt  <= bcnt + 1'b1;
                    if (bcnt == 3'd7) state <= AFTER_DATA;
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (bit_end) begin
                    par_bad <= rx ^ (^shreg);
                    state   <= STOP;
                end
`endif
                STOP: if (bit_end) begin
                    Rx_DATA   <= shreg;
                    Rx_FERROR <= !rx;
                    need_high <= !rx;
`ifdef UART_RX_PARITY_EN
                    Rx_VALID  <= rx && !par_bad;
                    Rx_PERROR <= par_bad;
`else
                    Rx_VALID  <= rx;
`endif
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Receive side of the UART link; the counterpart of uart_transmitter.
- Oversamples the serial line RxD at 16x the selected baud rate and recovers 8N1 frames: start bit, 8 data bits LSB-first, stop bit.
- With the optional parity feature, frames carry an even-parity bit before the stop bit.
- Presents each received byte with a one-cycle valid strobe and error flags.
- Shares the baud_select encoding with the transmitter so that both ends use one setting.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the RxD metastability synchroniser; minimum 2.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- baud_select  in  3  baud rate code; same table as the transmitter.
- Rx_EN  in  1  receiver enable; when low the receiver is held idle.
- RxD  in  1  asynchronous serial input; idles high.
- Rx_DATA  out  8  last received byte.
- Rx_VALID  out  1  one-cycle strobe: a frame completed with no error.
- Rx_FERROR  out  1  one-cycle strobe: the stop bit was sampled as 0.
- Rx_PERROR  out  1  one-cycle strobe: parity mismatch (parity build only).

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high.
- Reset values: Rx_DATA=8'h00, Rx_VALID=0, Rx_FERROR=0, Rx_PERROR=0, state=IDLE, synchroniser flops=1, sample counter=0.
- Sample tick: a divider generates sample_en once every DIV clk cycles. DIV is selected by baud_select:
  - 000 → 10417 (300 baud)
  - 001 → 2604 (1200)
  - 010 → 651 (4800)
  - 011 → 326 (9600)
  - 100 → 163 (19200)
  - 101 → 81 (38400)
  - 110 → 54 (57600)
  - 111 → 27 (115200)
- Divider alignment: the divider restarts from 0 in the cycle the FSM leaves IDLE, so sample phase is aligned to the start edge. baud_select is latched at the same moment; changing it mid-frame has no effect until the next frame.
- IDLE: wait for Rx_EN=1 and synchronised RxD=0, then go to START.
- START: count 8 ticks (mid-bit) and resample.
  - If RxD=1, this is a false start: return to IDLE with no outputs.
  - Otherwise go to DATA.
- DATA: sample every 16 ticks and shift into bit position 0..7, LSB first. After bit 7, go to PARITY (parity build) or STOP.
- PARITY: sample at 16 ticks and compare with XOR of the data bits (even parity).
- STOP: sample at 16 ticks, then in the next clk:
  - Load Rx_DATA with the byte even when the frame has errors.
  - Pulse exactly one of Rx_VALID or the applicable error flags for one cycle. Both error flags may assert together.
  - Return to IDLE.
  - If RxD is already low at that point, the next frame is accepted without requiring an idle-high cycle.
- Latency: the strobe fires about 9.5 bit times after the start edge (10.5 bit times in the parity build), plus SYNC_STAGES+1 clk.
- Rx_EN deasserted mid-frame: abort to IDLE in the next clk, discard the partial byte, emit no strobe, leave Rx_DATA unchanged.
- reset mid-frame: immediately restore the reset values.
- Break condition (line held low): produces a frame with Rx_DATA=8'h00 and Rx_FERROR. The receiver then stays in IDLE until RxD returns high and falls again.
  - Edge qualification: a start bit is recognised only on a 1→0 transition after a reported framing error. Normally the FSM accepts a low level in IDLE.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: frame is start + 8 data + even parity + stop (11 bits). The PARITY state exists and Rx_PERROR is driven. Must match a transmitter built with the same macro.
- Undefined: frame is 10 bits. The PARITY state is not generated and Rx_PERROR is tied to 0.

Decomposition:
- Shared package uart_pkg holds:
  - the baud_select → DIV constant table, shared with uart_transmitter;
  - the FSM state encoding (IDLE, START, DATA, PARITY, STOP);
  - OVERSAMPLE=16 and MID_SAMPLE=8.
- One sub-module: baud_controller (baud_select, restart → sample_en). It is instantiated by both the transmitter and the receiver.

Test Plan:
- baud_select=111, Rx_EN=1, drive 8'hA5 (parity 0) at 432 clk/bit → one Rx_VALID pulse, Rx_DATA=8'hA5, no error flags.
- Two back-to-back frames 8'h00 then 8'hFF with no idle gap → two Rx_VALID pulses, Rx_DATA ends at 8'hFF.
- Frame 8'h3C with stop bit driven 0 → Rx_FERROR pulses, Rx_VALID stays 0, Rx_DATA=8'h3C.
- Parity build: frame 8'h01 with parity bit 0 → Rx_PERROR pulses, no Rx_VALID.
- Low glitch of 100 clk on idle RxD → false start, no strobe, FSM back in IDLE.
- Rx_EN dropped at data bit 4 of 8'h55 → no strobe, Rx_DATA unchanged. A reset pulse mid-frame returns all outputs to their reset values.
